// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle FSM stepping IF/ID/EX/MEM/WB with memory handshake,
// optional stall timeout and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int MAX_WAIT      = 0,
    parameter int WAIT_W        = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             mem_ready,
    input  logic             halt_cond,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             is_halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic              rdy;
    logic              stall;
    logic              timeout;
    logic [2:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;

    assign rdy     = (MEM_HANDSHAKE == 0) || mem_ready;
    assign stall   = !rdy && (state == S_IF ||
                     (state == S_MEM && (opcode == OP_LOAD || opcode == OP_STORE)));
    // mem_ready in the last allowed cycle still wins because stall requires !rdy
    assign timeout = (MAX_WAIT != 0) && stall && wait_cnt == WAIT_LAST;

    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_to_reg  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        next_state = state;
        case (state)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = rdy & ~reset;
                next_state = rdy ? S_ID : S_IF;
            end
            S_ID: begin
                alu_src_b = 2'd2;
                case (opcode)
                    OP_JAL: begin
                        reg_write  = 1'b1;
                        pc_to_reg  = 1'b1;
                        pc_write   = 1'b1;
                        pc_source  = 2'd2;
                        next_state = S_IF;
                    end
                    OP_ECALL: begin
                        pc_write   = !halt_cond;
                        next_state = halt_cond ? S_HALT : S_IF;
                    end
                    OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_BRANCH:
                        next_state = S_EX;
                    default: begin
                        pc_write   = 1'b1;
                        next_state = S_IF;
                    end
                endcase
            end
            S_EX: begin
                alu_src_a  = 1'b1;
                next_state = S_IF;
                case (opcode)
                    OP_ARITH: begin
                        alu_op     = 2'b10;
                        next_state = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_b  = 2'd2;
                        alu_op     = 2'b10;
                        next_state = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b  = 2'd2;
                        next_state = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op    = 2'b01;
                        pc_write  = 1'b1;
                        pc_source = {1'b0, bcond};
                    end
                    OP_JALR: begin
                        alu_src_b = 2'd2;
                        reg_write = 1'b1;
                        pc_to_reg = 1'b1;
                        pc_write  = 1'b1;
                        pc_source = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = opcode == OP_LOAD;
                mem_write = opcode == OP_STORE;
                pc_write  = opcode == OP_STORE && rdy;
                next_state = opcode == OP_LOAD  ? (rdy ? S_WB : S_MEM) :
                             opcode == OP_STORE ? (rdy ? S_IF : S_MEM) : S_IF;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = opcode == OP_LOAD;
                next_state = S_IF;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
        if (timeout)
            next_state = S_HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IF;
            wait_cnt    <= '0;
            instr_count <= '0;
            is_halted   <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= (next_state != state) ? '0 : stall ? wait_cnt + WAIT_W'(1) : wait_cnt;
            instr_count <= instr_count + CNT_W'(pc_write);
            if (next_state == S_HALT)
                is_halted <= 1'b1;
            if (timeout)
                bus_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table vectors, directed multi-cycle sequences and random stimulus
// against an instruction-path reference model, on a default instance and a MAX_WAIT=4/CNT_W=4 one.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] state;
        logic       is_halted;
        logic       bus_error;
    } obs_t;
    typedef struct {int op, bc, st, pcw, src, aop, asb;} vec_t;
    typedef enum int {C_ARITH, C_ARITHI, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ECALL, C_OTHER} cls_e;
    localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] opcode = 7'h0;
    logic bcond = 1'b0, mem_ready = 1'b0, halt_cond = 1'b0;
    obs_t a_o, b_o;
    logic [31:0] a_cnt;
    logic [3:0] b_cnt;

    int n_cmp = 0, n_bad = 0;
    int m_ph[2], m_w[2];
    logic [31:0] m_cnt[2];
    logic m_halt[2], m_berr[2];
    int max_w[2] = '{0, 4};
    logic [31:0] cmask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
    obs_t p_o[2];
    int p_np[2];
    bit p_rt[2], p_to[2], p_blk[2];
    logic [6:0] ops[8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73};
    vec_t tbl[19];

    always #5 clk = ~clk;

    multicycle_control_unit dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
        .halt_cond(halt_cond), .pc_write(a_o.pc_write), .pc_source(a_o.pc_source),
        .ir_write(a_o.ir_write), .i_or_d(a_o.i_or_d), .mem_read(a_o.mem_read),
        .mem_write(a_o.mem_write), .mem_to_reg(a_o.mem_to_reg), .reg_write(a_o.reg_write),
        .pc_to_reg(a_o.pc_to_reg), .alu_src_a(a_o.alu_src_a), .alu_src_b(a_o.alu_src_b),
        .alu_op(a_o.alu_op), .is_halted(a_o.is_halted), .bus_error(a_o.bus_error),
        .instr_count(a_cnt), .state(a_o.state)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(1), .MAX_WAIT(4), .WAIT_W(8), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
        .halt_cond(halt_cond), .pc_write(b_o.pc_write), .pc_source(b_o.pc_source),
        .ir_write(b_o.ir_write), .i_or_d(b_o.i_or_d), .mem_read(b_o.mem_read),
        .mem_write(b_o.mem_write), .mem_to_reg(b_o.mem_to_reg), .reg_write(b_o.reg_write),
        .pc_to_reg(b_o.pc_to_reg), .alu_src_a(b_o.alu_src_a), .alu_src_b(b_o.alu_src_b),
        .alu_op(b_o.alu_op), .is_halted(b_o.is_halted), .bus_error(b_o.bus_error),
        .instr_count(b_cnt), .state(b_o.state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            7'h33: return C_ARITH;
            7'h13: return C_ARITHI;
            7'h03: return C_LOAD;
            7'h23: return C_STORE;
            7'h63: return C_BRANCH;
            7'h6F: return C_JAL;
            7'h67: return C_JALR;
            7'h73: return C_ECALL;
            default: return C_OTHER;
        endcase
    endfunction

    // Each instruction class walks IF -> ID -> ... and retires in the last phase of its path
    function automatic int final_phase(input cls_e c);
        case (c)
            C_ARITH, C_ARITHI, C_LOAD: return P_WB;
            C_STORE: return P_MEM;
            C_BRANCH, C_JALR: return P_EX;
            default: return P_ID;
        endcase
    endfunction

    function automatic void predict(input int k);
        cls_e c;
        int ph, last;
        bit halt_ecall, links;
        obs_t o;
        c = classify(opcode);
        ph = m_ph[k];
        last = final_phase(c);
        o = '0;
        o.state = 3'(ph);
        o.is_halted = m_halt[k];
        o.bus_error = m_berr[k];
        p_blk[k] = (ph == P_IF || ph == P_MEM) && !mem_ready;
        halt_ecall = ph == P_ID && c == C_ECALL && halt_cond;
        p_to[k] = p_blk[k] && max_w[k] != 0 && m_w[k] == max_w[k] - 1;
        p_rt[k] = ph == last && !p_blk[k] && !halt_ecall;
        if (ph == P_HALT || p_to[k] || halt_ecall) p_np[k] = P_HALT;
        else if (p_blk[k]) p_np[k] = ph;
        else if (ph == last) p_np[k] = P_IF;
        else p_np[k] = ph == P_IF ? P_ID : ph == P_ID ? P_EX :
                       (ph == P_EX && (c == C_LOAD || c == C_STORE)) ? P_MEM : P_WB;
        links = (c == C_JAL && ph == P_ID) || (c == C_JALR && ph == P_EX);
        o.pc_write = p_rt[k];
        o.pc_source = links ? 2'd2 : (ph == P_EX && c == C_BRANCH && bcond) ? 2'd1 : 2'd0;
        o.ir_write = ph == P_IF && mem_ready && !reset;
        o.i_or_d = ph == P_MEM;
        o.mem_read = ph == P_IF || (ph == P_MEM && c == C_LOAD);
        o.mem_write = ph == P_MEM && c == C_STORE;
        o.mem_to_reg = ph == P_WB && c == C_LOAD;
        o.reg_write = links || ph == P_WB;
        o.pc_to_reg = links;
        o.alu_src_a = ph == P_EX;
        o.alu_src_b = (ph == P_ID || (ph == P_EX && c != C_ARITH && c != C_BRANCH)) ? 2'd2 : 2'd0;
        o.alu_op = ph != P_EX ? 2'd0 : (c == C_ARITH || c == C_ARITHI) ? 2'd2 :
                   c == C_BRANCH ? 2'd1 : 2'd0;
        p_o[k] = o;
    endfunction

    task automatic drive(input logic [6:0] op, input logic bc, input logic rdy, input logic hc);
        opcode = op;
        bcond = bc;
        mem_ready = rdy;
        halt_cond = hc;
        #1;
        for (int k = 0; k < 2; k++) begin
            predict(k);
            chk($sformatf("outputs[%0d]", k), 32'(k == 0 ? a_o : b_o), 32'(p_o[k]));
            chk($sformatf("instr_count[%0d]", k), k == 0 ? a_cnt : 32'(b_cnt), m_cnt[k]);
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            if (p_np[k] != m_ph[k]) m_w[k] = 0;
            else if (p_blk[k]) m_w[k]++;
            if (p_rt[k]) m_cnt[k] = (m_cnt[k] + 32'd1) & cmask[k];
            if (p_np[k] == P_HALT) m_halt[k] = 1'b1;
            if (p_to[k]) m_berr[k] = 1'b1;
            m_ph[k] = p_np[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [6:0] op, input logic bc, input logic rdy, input logic hc);
        drive(op, bc, rdy, hc);
        tick();
    endtask

    // Asserted away from the clock edge so the asynchronous clear is observed immediately
    task automatic do_reset();
        obs_t e;
        e = '0;
        e.mem_read = 1'b1;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'h33;
        bcond = 1'b0;
        halt_cond = 1'b0;
        #1;
        chk("reset_outputs_a", 32'(a_o), 32'(e));
        chk("reset_outputs_b", 32'(b_o), 32'(e));
        chk("reset_counts", a_cnt | 32'(b_cnt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_IF;
            m_w[k] = 0;
            m_cnt[k] = 32'd0;
            m_halt[k] = 1'b0;
            m_berr[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic rdy;
        logic [6:0] cur;
        tbl = '{'{'h33,0,0,0,0,0,0}, '{'h33,0,1,0,0,0,2}, '{'h33,0,2,0,0,2,0}, '{'h33,0,4,1,0,0,0},
                '{'h63,1,0,0,0,0,0}, '{'h63,1,1,0,0,0,2}, '{'h63,1,2,1,1,1,0},
                '{'h63,0,0,0,0,0,0}, '{'h63,0,1,0,0,0,2}, '{'h63,0,2,1,0,1,0},
                '{'h67,0,0,0,0,0,0}, '{'h67,0,1,0,0,0,2}, '{'h67,0,2,1,2,0,2},
                '{'h6F,0,0,0,0,0,0}, '{'h6F,0,1,1,2,0,2},
                '{'h13,0,0,0,0,0,0}, '{'h13,0,1,0,0,0,2}, '{'h13,0,2,0,0,2,2}, '{'h13,0,4,1,0,0,0}};
        #2;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(7'(tbl[i].op), 1'(tbl[i].bc), 1'b1, 1'b0);
            chk($sformatf("table[%0d]", i),
                32'({a_o.state, a_o.pc_write, a_o.pc_source, a_o.alu_op, a_o.alu_src_b}),
                32'({3'(tbl[i].st), 1'(tbl[i].pcw), 2'(tbl[i].src), 2'(tbl[i].aop), 2'(tbl[i].asb)}));
            tick();
        end
        drive(7'h00, 1'b0, 1'b1, 1'b0);
        chk("count_after_table", a_cnt, 32'd6);
        tick();
        // LOAD with three stalled MEM cycles; instance b must not time out (ready arrives in time)
        step(7'h03, 1'b0, 1'b1, 1'b0);
        step(7'h03, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(7'h03, 1'b0, i == 3, 1'b0);
            chk($sformatf("load_mem[%0d]", i), 32'({a_o.mem_read, a_o.i_or_d, b_o.state}), 32'({2'b11, 3'd3}));
            tick();
        end
        drive(7'h03, 1'b0, 1'b1, 1'b0);
        chk("load_wb", 32'({a_o.state, a_o.mem_to_reg, a_o.reg_write, a_o.pc_write, b_o.bus_error}), 32'({3'd4, 4'b1110}));
        tick();
        step(7'h23, 1'b0, 1'b1, 1'b0);
        step(7'h23, 1'b0, 1'b1, 1'b0);
        step(7'h23, 1'b0, 1'b1, 1'b0);
        step(7'h23, 1'b0, 1'b0, 1'b0);
        step(7'h23, 1'b0, 1'b0, 1'b0);
        step(7'h23, 1'b0, 1'b1, 1'b0);
        // ECALL with halt condition: halts from ID without retiring
        step(7'h73, 1'b0, 1'b1, 1'b1);
        drive(7'h73, 1'b0, 1'b1, 1'b1);
        chk("ecall_id_no_retire", 32'({a_o.state, a_o.pc_write}), 32'({3'd1, 1'b0}));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(7'h73, 1'b0, 1'b1, 1'b0);
            chk("ecall_halted", 32'({a_o.state, a_o.is_halted, a_o.mem_read, a_o.bus_error}), 32'({3'd5, 3'b100}));
            chk("ecall_count_held", a_cnt, 32'd8);
            tick();
        end
        do_reset();
        step(7'h73, 1'b0, 1'b1, 1'b0);
        drive(7'h73, 1'b0, 1'b1, 1'b0);
        chk("ecall_retire", 32'({a_o.state, a_o.pc_write, a_o.pc_source}), 32'({3'd1, 3'b100}));
        tick();
        // Fetch stuck without ready: instance b halts with bus_error after four cycles
        do_reset();
        for (int i = 0; i < 4; i++) step(7'h33, 1'b0, 1'b0, 1'b0);
        drive(7'h33, 1'b0, 1'b0, 1'b0);
        chk("timeout_halt", 32'({b_o.state, b_o.bus_error, b_o.is_halted, b_o.mem_read, b_o.ir_write}), 32'({3'd5, 4'b1100}));
        chk("no_timeout_default", 32'({a_o.state, a_o.bus_error, a_o.mem_read}), 32'({3'd0, 2'b01}));
        tick();
        // 4-bit counter wrap with JALs, then asynchronous reset mid-MEM
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(7'h6F, 1'b0, 1'b1, 1'b0);
            if (i == 15) chk("cnt4_before_wrap", 32'(b_cnt), 32'd15);
            tick();
            step(7'h6F, 1'b0, 1'b1, 1'b0);
        end
        drive(7'h03, 1'b0, 1'b1, 1'b0);
        chk("cnt4_wrapped", 32'(b_cnt), 32'd0);
        chk("cnt32_no_wrap", a_cnt, 32'd16);
        tick();
        step(7'h03, 1'b0, 1'b1, 1'b0);
        step(7'h03, 1'b0, 1'b1, 1'b0);
        drive(7'h03, 1'b0, 1'b0, 1'b0);
        chk("in_mem_before_reset", 32'(a_o.state), 32'd3);
        tick();
        do_reset();
        cur = 7'h33;
        for (int i = 0; i < 1500; i++) begin
            if (m_ph[0] == P_HALT || m_ph[1] == P_HALT) begin
                do_reset();
            end else begin
                rdy = $urandom_range(0, 9) < 7;
                if (m_ph[0] == P_IF) begin
                    if (rdy) cur = $urandom_range(0, 8) == 8 ? 7'($urandom) : ops[$urandom_range(0, 7)];
                    step(7'($urandom), 1'($urandom), rdy, 1'($urandom));
                end else begin
                    step(cur, 1'($urandom), rdy, $urandom_range(0, 15) == 0);
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
